fme_sad_sel: RTL and testbench
==============================

# fme_sad_sel

Fractional motion-estimation cost stage placed directly downstream of the FME interpolator array. Each beat carries one row of clipped 8-bit interpolated reference pixels and the co-located current-block pixels. The block accumulates the SAD of that row per fractional candidate over a block. After the last candidate it reports the index and cost of the cheapest candidate to the FME controller.

## Interface

- `LANES`, 8: pixels per beat (one block row); legal values 4 or 8.
- `BLK_ROWS`, 8: rows per candidate block; legal range 4..32.
- `CAND_NUM`, 9: fractional candidates per search (centre plus 8 neighbours); legal range 1..16.
- `clk` input 1: clock. Rising edge only.
- `rst` input 1: reset. Synchronous, active-high, one clock.
- `start_i` input 1: begin a search. Sampled only in IDLE.
- `valid_i` input 1: beat valid.
- `ref_pix_i` input LANES*8: interpolated reference row. Lane k is bits [8k+7:8k].
- `cur_pix_i` input LANES*8: current-block row, same lane packing.
- `ready_o` output 1: beats are accepted while high.
- `done_o` output 1: one-cycle pulse; results are valid in that cycle.
- `best_idx_o` output 4: index of the winning candidate.
- `best_cost_o` output 16: SAD of the winning candidate.

## Operation

- Beat order is candidate-major: candidate 0 rows 0..BLK_ROWS-1, then candidate 1, and so on up to CAND_NUM-1.
- A beat is accepted when `valid_i` and `ready_o` are both high.
- Beat SAD is the sum over lanes of |ref−cur|, computed on unsigned 8-bit operands. It is 11 bits wide (max 2040).
- The candidate accumulator is 16 bits. With the parameter limits the maximum is 65280, so it cannot overflow and needs no saturation.
- Counters:
  - `row_cnt` runs 0..BLK_ROWS-1.
  - `cand_cnt` runs 0..CAND_NUM-1.
  - Both wrap to 0 when a search completes.
- Candidate close:
  - On the final row of each candidate, the completed sum (accumulator plus the current beat SAD) is compared against `best_cost`.
  - The sum replaces `best_cost` and `best_idx` only if it is strictly less. On ties the lower index wins.
  - The accumulator then clears for the next candidate.
- FSM states:
  - IDLE: `ready_o`=0. `start_i`=1 → ACC. On entry to ACC, counters and accumulator clear, `best_cost` is set to 16'hFFFF and `best_idx` to 0.
  - ACC: `ready_o`=1. Accepting the final beat of candidate CAND_NUM-1 → DRAIN if `FME_SAD_PIPE_EN` is defined, otherwise → DONE.
  - DRAIN: `ready_o`=0 for one cycle while the last pipelined SAD is folded in, then → DONE.
  - DONE: `done_o`=1 for exactly one cycle, then → IDLE.
- Ignored inputs:
  - `start_i` is ignored outside IDLE.
  - `valid_i` is ignored outside ACC.
  - `ready_o` never deasserts mid-candidate, so there is no back-pressure inside a search.
- `best_idx_o`/`best_cost_o` hold their last values until the next DONE. They are not cleared by `start_i`.
- Reset mid-search aborts the search: FSM → IDLE, all counters and accumulators clear, outputs take their reset values.

## Timing

- Reset values:
  - `ready_o`=0, `done_o`=0.
  - `best_idx_o`=0, `best_cost_o`=16'hFFFF.
  - FSM in IDLE.
- `start_i` sampled at edge N → `ready_o`=1 from cycle N+1.
- Throughput: one beat per cycle with no bubbles required. Gaps with `valid_i` low are allowed at any point; counters hold during gaps.
- Latency, from the edge accepting the final beat (E) to `done_o`:
  - Without the pipeline: `done_o` is high in cycle E+1.
  - With `FME_SAD_PIPE_EN`: `done_o` is high in cycle E+2.
- `start_i` high in the DONE cycle is ignored. A back-to-back search needs `start_i` in the following IDLE cycle, so the minimum turnaround is one idle cycle.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration

- `FME_SAD_PIPE_EN` defined: a register stage sits between the lane abs-diff/adder tree and the accumulator.
  - The beat SAD and a "last row"/"last candidate" tag are registered, and accumulation and comparison use the registered values.
  - DRAIN state is used; latency is +1 cycle.
- `FME_SAD_PIPE_EN` undefined: the adder tree feeds the accumulator combinationally, and DRAIN is never entered.
- Cost results are identical in both builds.

## Test plan

- Reset with default parameters → `ready_o`=0, `done_o`=0, `best_idx_o`=0, `best_cost_o`=16'hFFFF.
- Start, then 72 back-to-back beats with all cur=100 and ref=100, except candidate 4 where ref=99 in every lane. Required: candidate 4 has SAD 64, all others have SAD 0. Expect `best_idx_o`=0, `best_cost_o`=0, `done_o` at E+1 (E+2 with the macro).
- Candidate c has ref−cur = 9−c on every pixel → SAD 64*(9−c). Expect `best_idx_o`=8, `best_cost_o`=64.
- Tie: candidates 3 and 6 both have SAD 10, all others 200. Expect `best_idx_o`=3, `best_cost_o`=10.
- Max case: cur=0, ref=255 for all 72 beats. Expect `best_cost_o`=16320, `best_idx_o`=0.
- Random `valid_i` gaps plus `start_i` pulses during ACC give the same results as the gap-free run. Asserting `rst` after 30 beats returns the block to reset values. A fresh search after that reset completes correctly.

Source files
------------

// File: rtl/fme_sad_sel.sv
// fme_sad_sel: accumulates row SADs per fractional candidate and reports the cheapest one (optional FME_SAD_PIPE_EN).
// Latency: done_o one cycle after the final beat is accepted, two cycles with FME_SAD_PIPE_EN.
// Backpressure: ready_o stays high for the entire search and low otherwise; never stalls mid-search.
module fme_sad_sel #(
    parameter int LANES    = 8,
    parameter int BLK_ROWS = 8,
    parameter int CAND_NUM = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               valid_i,
    input  logic [LANES*8-1:0] ref_pix_i,
    input  logic [LANES*8-1:0] cur_pix_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [3:0]         best_idx_o,
    output logic [15:0]        best_cost_o
);
    localparam int            RW        = $clog2(BLK_ROWS);
    localparam logic [RW-1:0] ROW_LAST  = RW'(BLK_ROWS - 1);
    localparam logic [3:0]    CAND_LAST = 4'(CAND_NUM - 1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t        state;
    logic [RW-1:0] row_cnt;
    logic [3:0]    cand_cnt;
    logic [15:0]   acc;
    logic [15:0]   best_cost;
    logic [3:0]    best_idx;

    logic          accept;
    logic          last_row_now;
    logic          last_cand_now;
    logic [10:0]   beat_sad;

    logic          fold_vld;
    logic          fold_last_row;
    logic          fold_last_cand;
    logic [3:0]    fold_cand;
    logic [10:0]   fold_sad;
    logic [15:0]   sum;
    logic          better;
    logic [15:0]   nxt_best_cost;
    logic [3:0]    nxt_best_idx;

    function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        beat_sad = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sad = beat_sad + 11'(absdiff8(ref_pix_i[8*k +: 8], cur_pix_i[8*k +: 8]));
        end
    end

    assign accept        = valid_i && ready_o;
    assign last_row_now  = (row_cnt == ROW_LAST);
    assign last_cand_now = (cand_cnt == CAND_LAST);

`ifdef FME_SAD_PIPE_EN
    logic        p_vld;
    logic        p_last_row;
    logic        p_last_cand;
    logic [3:0]  p_cand;
    logic [10:0] p_sad;

    assign fold_vld       = p_vld;
    assign fold_sad       = p_sad;
    assign fold_last_row  = p_last_row;
    assign fold_last_cand = p_last_cand;
    assign fold_cand      = p_cand;
`else
    assign fold_vld       = accept;
    assign fold_sad       = beat_sad;
    assign fold_last_row  = last_row_now;
    assign fold_last_cand = last_cand_now;
    assign fold_cand      = cand_cnt;
`endif

    // Strict less-than keeps the earlier (lower) index on ties.
    assign sum           = acc + 16'(fold_sad);
    assign better        = fold_last_row && (sum < best_cost);
    assign nxt_best_cost = better ? sum : best_cost;
    assign nxt_best_idx  = better ? fold_cand : best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready_o     <= 1'b0;
            done_o      <= 1'b0;
            row_cnt     <= '0;
            cand_cnt    <= '0;
            acc         <= '0;
            best_cost   <= 16'hFFFF;
            best_idx    <= '0;
            best_idx_o  <= '0;
            best_cost_o <= 16'hFFFF;
`ifdef FME_SAD_PIPE_EN
            p_vld       <= 1'b0;
            p_last_row  <= 1'b0;
            p_last_cand <= 1'b0;
            p_cand      <= '0;
            p_sad       <= '0;
`endif
        end else begin
            done_o <= 1'b0;

`ifdef FME_SAD_PIPE_EN
            p_vld       <= accept;
            p_last_row  <= last_row_now;
            p_last_cand <= last_cand_now;
            p_cand      <= cand_cnt;
            p_sad       <= beat_sad;
`endif

            if (accept) begin
                if (last_row_now) begin
                    row_cnt  <= '0;
                    cand_cnt <= last_cand_now ? 4'd0 : cand_cnt + 4'd1;
                end else begin
                    row_cnt <= row_cnt + RW'(1);
                end
            end

            if (fold_vld) begin
                if (fold_last_row) begin
                    acc       <= '0;
                    best_cost <= nxt_best_cost;
                    best_idx  <= nxt_best_idx;
                    if (fold_last_cand) begin
                        best_cost_o <= nxt_best_cost;
                        best_idx_o  <= nxt_best_idx;
                    end
                end else begin
                    acc <= sum;
                end
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= ACC;
                        ready_o   <= 1'b1;
                        row_cnt   <= '0;
                        cand_cnt  <= '0;
                        acc       <= '0;
                        best_cost <= 16'hFFFF;
                        best_idx  <= '0;
                    end
                end
                ACC: begin
                    if (accept && last_row_now && last_cand_now) begin
                        ready_o <= 1'b0;
`ifdef FME_SAD_PIPE_EN
                        state   <= DRAIN;
`else
                        state   <= DONE;
                        done_o  <= 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fme_sad_sel.sv
// Randomised self-checking bench for fme_sad_sel against a per-candidate SAD model.
module tb_fme_sad_sel;
    localparam int LANES    = 8;
    localparam int BLK_ROWS = 8;
    localparam int CAND_NUM = 9;
    localparam int TOTAL    = BLK_ROWS * CAND_NUM;
`ifdef FME_SAD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic               valid_i = 1'b0;
    logic [LANES*8-1:0] ref_pix_i = '0;
    logic [LANES*8-1:0] cur_pix_i = '0;
    logic               ready_o;
    logic               done_o;
    logic [3:0]         best_idx_o;
    logic [15:0]        best_cost_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    fme_sad_sel #(.LANES(LANES), .BLK_ROWS(BLK_ROWS), .CAND_NUM(CAND_NUM)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
        .ref_pix_i(ref_pix_i), .cur_pix_i(cur_pix_i),
        .ready_o(ready_o), .done_o(done_o),
        .best_idx_o(best_idx_o), .best_cost_o(best_cost_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks which beats are accepted and the per-candidate SAD totals.
    logic        m_ready = 1'b0;
    logic        m_done  = 1'b0;
    logic [3:0]  m_bidx  = '0;
    logic [15:0] m_bcost = 16'hFFFF;
    int          m_cnt   = 0;
    bit          m_tail  = 1'b0;
    bit          m_cool  = 1'b0;
    int          m_sad[16];

    function automatic int row_sad(input logic [LANES*8-1:0] r, input logic [LANES*8-1:0] c);
        int s = 0;
        for (int k = 0; k < LANES; k++) begin
            int a = int'(r[8*k +: 8]);
            int b = int'(c[8*k +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    task automatic publish();
        m_bcost = 16'hFFFF;
        m_bidx  = '0;
        for (int c = 0; c < CAND_NUM; c++) begin
            if (m_sad[c] < int'(m_bcost)) begin
                m_bcost = 16'(m_sad[c]);
                m_bidx  = 4'(c);
            end
        end
        m_done = 1'b1;
        m_cool = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b0; m_done = 1'b0; m_bidx = '0; m_bcost = 16'hFFFF;
            m_cnt = 0; m_tail = 1'b0; m_cool = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_tail) begin
                m_tail = 1'b0;
                publish();
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (!m_ready) begin
                if (start_i) begin
                    m_ready = 1'b1;
                    m_cnt   = 0;
                    for (int c = 0; c < 16; c++) m_sad[c] = 0;
                end
            end else if (valid_i) begin
                m_sad[m_cnt / BLK_ROWS] += row_sad(ref_pix_i, cur_pix_i);
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_ready = 1'b0;
                    if (LAT == 2) m_tail = 1'b1;
                    else publish();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", ready_o, m_ready);
            chk("cyc_done", done_o, m_done);
            chk("cyc_best_idx", best_idx_o, m_bidx);
            chk("cyc_best_cost", best_cost_o, m_bcost);
        end
    end

    logic [LANES*8-1:0] rnd_ref[TOTAL];
    logic [LANES*8-1:0] rnd_cur[TOTAL];

    task automatic gen_beat(input int mode, input int i,
                            output logic [LANES*8-1:0] r, output logic [LANES*8-1:0] c);
        int cand = i / BLK_ROWS;
        int row  = i % BLK_ROWS;
        r = '0;
        c = '0;
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                0: begin c[8*k +: 8] = 8'd100; r[8*k +: 8] = (cand == 4) ? 8'd99 : 8'd100; end
                1: begin c[8*k +: 8] = 8'd100; r[8*k +: 8] = 8'(109 - cand); end
                2: begin
                    c[8*k +: 8] = 8'd50;
                    if (cand == 3 || cand == 6) r[8*k +: 8] = (row == 0 && k == 0) ? 8'd60 : 8'd50;
                    else                        r[8*k +: 8] = (row == 0) ? 8'd75 : 8'd50;
                end
                3: begin c[8*k +: 8] = 8'd0; r[8*k +: 8] = 8'd255; end
                default: begin r = rnd_ref[i]; c = rnd_cur[i]; end
            endcase
        end
    endtask

    // Drives one search; abort_n > 0 stops after that many beats and pulses rst.
    task automatic run_search(input int mode, input bit gaps, input bit noise, input int abort_n);
        int n = (abort_n > 0) ? abort_n : TOTAL;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_i   = 1'b0;
                    start_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    ref_pix_i = {$urandom, $urandom};
                    cur_pix_i = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            start_i = 1'b0;
            valid_i = 1'b1;
            gen_beat(mode, i, ref_pix_i, cur_pix_i);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        start_i = 1'b0;
        if (abort_n > 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic finish_search(input string nm, input bit start_in_done);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin lat = i; break; end
        end
        chk({nm, "_latency"}, lat, LAT);
        if (start_in_done) start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    logic [15:0] rnd_cost;
    logic [3:0]  rnd_idx;

    initial begin
        for (int i = 0; i < TOTAL; i++) begin
            rnd_ref[i] = {$urandom, $urandom};
            rnd_cur[i] = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_idx", best_idx_o, 0);
        chk("rst_cost", best_cost_o, 16'hFFFF);
        @(posedge clk); #1;

        run_search(0, 1'b0, 1'b0, 0);
        finish_search("one_off", 1'b0);
        chk("one_off_cost", best_cost_o, 0);
        chk("one_off_idx", best_idx_o, 0);
        chk("one_off_model_cand4", m_sad[4], 64);

        run_search(1, 1'b0, 1'b0, 0);
        finish_search("ramp", 1'b1);
        chk("ramp_cost", best_cost_o, 64);
        chk("ramp_idx", best_idx_o, 8);
        chk("ramp_model_cand0", m_sad[0], 576);

        run_search(2, 1'b0, 1'b0, 0);
        finish_search("tie", 1'b0);
        chk("tie_cost", best_cost_o, 10);
        chk("tie_idx", best_idx_o, 3);
        chk("tie_model_idx", m_bidx, 3);

        run_search(3, 1'b0, 1'b0, 0);
        finish_search("max", 1'b0);
        chk("max_cost", best_cost_o, 16320);
        chk("max_idx", best_idx_o, 0);

        run_search(4, 1'b0, 1'b0, 0);
        finish_search("rnd", 1'b0);
        rnd_cost = m_bcost;
        rnd_idx  = m_bidx;

        run_search(1, 1'b1, 1'b1, 0);
        finish_search("ramp_gap", 1'b0);
        chk("ramp_gap_cost", best_cost_o, 64);
        chk("ramp_gap_idx", best_idx_o, 8);

        run_search(4, 1'b1, 1'b1, 0);
        finish_search("rnd_gap", 1'b0);
        chk("rnd_gap_cost", best_cost_o, rnd_cost);
        chk("rnd_gap_idx", best_idx_o, rnd_idx);

        run_search(4, 1'b1, 1'b0, 30);
        @(negedge clk);
        chk("abort_ready", ready_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_idx", best_idx_o, 0);
        chk("abort_cost", best_cost_o, 16'hFFFF);
        @(posedge clk); #1;

        run_search(2, 1'b1, 1'b1, 0);
        finish_search("after_rst", 1'b0);
        chk("after_rst_cost", best_cost_o, 10);
        chk("after_rst_idx", best_idx_o, 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
